// File: rtl/prco_uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeds a four-state serialiser.
// The line idles high, and queued frames are sent back-to-back with no idle gap.
module prco_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [15:0]     baud_cnt, baud_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic [7:0]      shift, shift_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop, bit_done;

  // o_ready comes from the registered count, so a full FIFO refuses a push
  // even when a pop happens on the same edge.
  assign o_ready      = (count != CW'(FIFO_DEPTH));
  assign push         = i_valid && o_ready;
  assign bit_done     = (baud_cnt == 16'(CLKS_PER_BIT - 1));
  assign o_busy       = (state != IDLE) || (count != '0);
  assign o_fifo_count = count;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_nxt = state;
    baud_nxt  = baud_cnt + 16'd1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    pop       = 1'b0;
    o_tx      = 1'b1;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (count != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          bit_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        o_tx = 1'b0;
        if (bit_done) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        o_tx = shift[0];
        if (bit_done) begin
          baud_nxt  = '0;
          shift_nxt = shift >> 1;
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_nxt = '0;
          // Chain straight into the next start bit when more bytes are waiting.
          if (count != '0) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            bit_nxt   = '0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

endmodule

// File: doc/prco_uart_tx.md
# prco_uart_tx

Buffered 8N1 UART transmitter for the PRCO core, driving a serial output pin on the xc6lx9 MiniSpartan+ top level. It is the transmit counterpart to the serial receive path on PORTC3. The core or a memory-mapped port pushes bytes through a valid/ready handshake into a small FIFO. The block serialises those bytes back-to-back onto `o_tx` at a fixed bit period derived from the 50 MHz system clock.

## Interface
- `CLKS_PER_BIT`, default 434: system clocks per serial bit (50 MHz / 115200). Legal range 2..65535.
- `FIFO_DEPTH`, default 4: byte FIFO depth. Must be a power of 2, ≥ 2.

- `clk`  in  1  system clock (clk50 at top level); all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_data`  in  8  byte to transmit.
- `i_valid`  in  1  `i_data` is offered this cycle.
- `o_ready`  out  1  FIFO can accept a byte (not full).
- `o_tx`  out  1  serial line, idle high.
- `o_busy`  out  1  a frame is in progress or the FIFO is non-empty.
- `o_fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued (excluding the frame in flight).

## Operation
- Frame format is 8N1: start bit (0), data bits 0..7 LSB first, then one stop bit (1). A frame lasts 10·CLKS_PER_BIT cycles.
- Push: on a rising edge with `i_valid && o_ready`, `i_data` is written at the FIFO tail. `o_ready = (o_fifo_count != FIFO_DEPTH)`.
- The FIFO is circular with read/write pointers of width log2(FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH, and the count distinguishes full from empty.
- The FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: `o_tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud and bit counters, and go to START.
  - START: `o_tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `o_tx`=shift[0]. After each CLKS_PER_BIT cycles, shift right and increment the bit counter. After 8 bits, go to STOP.
  - STOP: `o_tx`=1 for CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at bit boundaries. Width is 16 bits.
- Push and pop in the same cycle: both take effect and `o_fifo_count` is unchanged. When full, push is refused even if a pop occurs in the same cycle, because `o_ready` is combinational from the registered count.
- `i_valid` while `o_ready`=0: the byte is dropped. No state change.
- `o_busy = (state != IDLE) || (o_fifo_count != 0)`.
- Reset (any time, including mid-frame):
  - next edge: `o_tx`=1, state=IDLE, FIFO emptied, counters cleared;
  - `o_ready`=1, `o_busy`=0, `o_fifo_count`=0;
  - the in-flight frame is abandoned (truncated on the line).

## Timing
- Push accepted at edge N into an empty FIFO while IDLE:
  - `o_fifo_count`=1 and `o_busy`=1 after edge N;
  - pop at edge N+1, so the start bit (`o_tx`=0) appears after edge N+1 and `o_fifo_count` returns to 0.
- Each bit level holds exactly CLKS_PER_BIT cycles. Data bit k begins (1+k)·CLKS_PER_BIT cycles after the start bit begins.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Sustained throughput is one byte per 10·CLKS_PER_BIT cycles. `o_ready` never deasserts if the producer pushes at or below that rate.
- `o_busy` falls on the cycle the FSM returns to IDLE with an empty FIFO.
- Outputs `o_tx`, `o_busy` and `o_fifo_count` are registered or derived from registered state. `o_ready` is combinational from the registered count.

## Test plan
- **Reset state:** with CLKS_PER_BIT=4, hold `reset` 3 cycles, then check `o_tx`=1, `o_ready`=1, `o_busy`=0 and `o_fifo_count`=0 for 20 idle cycles.
- **Single byte:** push 0x55 and check the `o_tx` sequence 0,1,0,1,0,1,0,1,0,1. Each level holds exactly 4 cycles, and the start bit begins 1 cycle after the push edge. `o_busy` must drop after 40 line cycles.
- **Back-to-back frames:** push 0xA3 then 0x0F on consecutive cycles. Check two frames with no idle cycle between the stop of 0xA3 and the start of 0x0F. Decoded LSB-first these read 0xA3 then 0x0F.
- **Fill the FIFO:** hold `i_valid` for 6 cycles with bytes 0x01..0x06 (FIFO_DEPTH=4).
  - The first byte pops, then four are queued, so `o_ready`=0 when `o_fifo_count`=4.
  - The sixth byte is dropped.
  - The line carries exactly 0x01..0x05.
- **Simultaneous push and pop:** queue 1 byte during a frame. Push a new byte on the last stop-bit cycle. `o_fifo_count` stays 1 across that edge, and both bytes transmit in order.
- **Reset mid-frame:** push 0x00, then assert `reset` during data bit 3. `o_tx`=1 after the next edge and stays high. The FIFO is empty, and a byte pushed after reset transmits correctly.
